spine_output_arbiter: RTL and testbench



---
 rtl/spine_arb_pkg.sv | 8 +
 rtl/spine_rr_pick.sv | 22 ++
 rtl/spine_output_arbiter.sv | 85 ++++++++
 tb/tb_spine_output_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spine_arb_pkg.sv
// spine_arb_pkg: shared FSM state, stat counter width and index-width helper for spine arbiters.
package spine_arb_pkg;
  typedef enum logic {IDLE, LOCK} arb_state_t;
  localparam int STAT_W = 16;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spine_rr_pick.sv
// spine_rr_pick: rotate-priority encoder, first set request at or after ptr (wrapping).
module spine_rr_pick #(
  parameter int N = 11,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] winner
);
  logic [N-1:0] rot;
  int wk;
  int s;
  assign rot = N'({req, req} >> ptr);
  assign found = |rot;
  always_comb begin
    wk = 0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) wk = k;
    s = int'(ptr) + wk;
    winner = W'(s >= N ? s - N : s);
  end
endmodule

// File: rtl/spine_output_arbiter.sv
// spine_output_arbiter: round-robin, packet-locked output scheduler with registered output.
// Optional per-requester grant counters when SPINE_ARB_STATS_EN is defined.
module spine_output_arbiter
  import spine_arb_pkg::*;
#(
  parameter int NUM_REQ = 11,
  parameter int DWIDTH  = 16,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_full,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy
`ifdef SPINE_ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]          stat_sel,
  output logic [STAT_W-1:0]         stat_cnt
`endif
);
  arb_state_t state;
  logic [IDX_W-1:0] ptr, pick, cand, nxt;
  logic found, sel_valid, sel_last, xfer;
  logic [DWIDTH-1:0] sel_data;
  spine_rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req(req_valid), .ptr(ptr), .found(found), .winner(pick)
  );
  // grant_idx doubles as the lock owner: in LOCK only the owner can transfer
  assign cand = state == LOCK ? grant_idx : pick;
  assign nxt = cand == IDX_W'(NUM_REQ - 1) ? '0 : cand + 1'b1;
  always_comb begin
    sel_valid = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (cand == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last = req_last[i];
        sel_data = req_data[i*DWIDTH +: DWIDTH];
      end
  end
  assign req_ready = (!reset && !out_full && (state == LOCK || found)) ? NUM_REQ'(1) << cand : '0;
  assign xfer = !reset && !out_full && (state == LOCK ? sel_valid : found);
  assign busy = state == LOCK;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant_idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_last <= sel_last;
        grant_idx <= cand;
        state <= sel_last ? IDLE : LOCK;
        if (sel_last) ptr <= nxt;
      end
    end
  end
`ifdef SPINE_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_REQ];
  // one count per packet, taken when the head is accepted out of IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (xfer && state == IDLE && cand == IDX_W'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      stat_cnt <= int'(stat_sel) < NUM_REQ ? cnt[stat_sel] : '0;
    end
  end
`endif
endmodule

// File: tb/tb_spine_output_arbiter.sv
// tb_spine_output_arbiter: random and directed stimulus against a per-cycle behavioural model.
module tb_spine_output_arbiter;
  localparam int N = 11, DW = 16, IW = 4;
  logic clk = 1'b0, reset = 1'b1, out_full = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0] out_data;
  logic out_valid, out_last, busy;
  logic [IW-1:0] grant_idx;
`ifdef SPINE_ARB_STATS_EN
  logic [IW-1:0] stat_sel = '0;
  logic [15:0] stat_cnt;
`endif
  always #5 clk = ~clk;
  spine_output_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_full(out_full), .grant_idx(grant_idx), .busy(busy)
`ifdef SPINE_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt)
`endif
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // model: lock flag, owner and rotation pointer; expected registered outputs for the coming cycle
  bit m_lock = 0;
  int m_owner = 0, m_ptr = 0, exp_grant = 0;
  logic exp_valid = 0, exp_last = 0, exp_busy = 0;
  logic [DW-1:0] exp_data = '0;
  int seen_g[$];
  logic [DW-1:0] seen_d[$];
  logic [N-1:0] er;
  always @(negedge clk) begin
    er = '0;
    if (!reset && !out_full) begin
      if (m_lock) er = N'(1) << m_owner;
      else for (int k = 0; k < N; k++) if (er == 0 && req_valid[(m_ptr + k) % N]) er = N'(1) << ((m_ptr + k) % N);
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("grant_idx", 32'(grant_idx), 32'(exp_grant));
    if (exp_valid) begin
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_last", 32'(out_last), 32'(exp_last));
    end
    if (out_valid) begin
      seen_g.push_back(int'(grant_idx));
      seen_d.push_back(out_data);
    end
    if (reset) begin
      m_lock = 0; m_ptr = 0; m_owner = 0;
      exp_valid = 0; exp_last = 0; exp_data = '0; exp_grant = 0;
    end else begin
      exp_valid = 0;
      for (int i = 0; i < N; i++)
        if (er[i] && req_valid[i]) begin
          exp_valid = 1;
          exp_data = req_data[i*DW +: DW];
          exp_last = req_last[i];
          exp_grant = i;
          if (req_last[i]) begin m_lock = 0; m_ptr = (i + 1) % N; end
          else begin m_lock = 1; m_owner = i; end
        end
    end
    exp_busy = m_lock;
  end
  initial begin
    int e2[6] = '{3, 3, 3, 3, 5, 2};
    int e3[4] = '{3, 3, 3, 7};
    int fidx[7] = '{0, 1, 2, 2, 2, 2, 3};
    bit fful[7] = '{0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(16'hA000 + i * 256);
    repeat (2) cyc();
    reset = 0;
    // all requesters, single-flit packets: strict rotation from 0 with wrap
    seen_g.delete();
    req_valid = '1; req_last = '1;
    repeat (12) cyc();
    req_valid = '0;
    cyc(); cyc();
    chk("s1_count", 32'(seen_g.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk("s1_order", 32'(i < seen_g.size() ? seen_g[i] : -1), 32'(i % 11));
    // move ptr to 3 with a single flit from input 2
    req_valid = N'(1) << 2; req_last = N'(1) << 2;
    cyc();
    req_valid = '0;
    cyc(); cyc();
    seen_g.delete();
    for (int k = 1; k <= 6; k++) begin
      req_valid = (k <= 4 ? N'(1) << 3 : '0) | (k <= 5 ? N'(1) << 5 : '0) | N'(1) << 2;
      req_last = (k == 4 ? N'(1) << 3 : '0) | N'(1) << 5 | N'(1) << 2;
      cyc();
    end
    req_valid = '0;
    cyc(); cyc();
    chk("s2_count", 32'(seen_g.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("s2_order", 32'(i < seen_g.size() ? seen_g[i] : -1), 32'(e2[i]));
    // owner 3 bubbles twice while 7 waits
    seen_g.delete();
    for (int k = 1; k <= 6; k++) begin
      req_valid = ((k == 1 || k == 2 || k == 5) ? N'(1) << 3 : '0) | N'(1) << 7;
      req_last = (k == 5 ? N'(1) << 3 : '0) | N'(1) << 7;
      cyc();
    end
    req_valid = '0;
    cyc(); cyc();
    chk("s3_count", 32'(seen_g.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("s3_order", 32'(i < seen_g.size() ? seen_g[i] : -1), 32'(e3[i]));
    // output full for three cycles mid-packet
    seen_d.delete();
    for (int k = 0; k < 7; k++) begin
      req_valid = N'(1);
      req_last = fidx[k] == 3 ? N'(1) : '0;
      req_data[0 +: DW] = 16'(16'h4400 + fidx[k]);
      out_full = fful[k];
      cyc();
    end
    req_valid = '0; req_last = '0;
    cyc(); cyc();
    chk("s4_count", 32'(seen_d.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("s4_data", 32'(i < seen_d.size() ? seen_d[i] : 16'hFFFF), 32'(16'h4400 + i));
    // reset while locked on 9
    req_valid = N'(1) << 9; req_last = '0;
    cyc(); cyc();
    reset = 1; req_valid = '0;
    cyc();
    reset = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    seen_g.delete();
    req_valid = N'(1) << 4; req_last = N'(1) << 4;
    cyc();
    req_valid = '0;
    chk("s5_grant_now", 32'(out_valid), 32'd1);
    cyc();
    chk("s5_count", 32'(seen_g.size()), 32'd1);
    chk("s5_owner", 32'(seen_g.size() > 0 ? seen_g[0] : -1), 32'd4);
    // randomized traffic, stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      req_last = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'($urandom);
      out_full = ($urandom % 5) == 0;
      reset = ($urandom % 200) == 0;
      cyc();
    end
    reset = 0; out_full = 0; req_valid = '0;
    cyc();
`ifdef SPINE_ARB_STATS_EN
    reset = 1;
    cyc();
    reset = 0;
    req_valid = N'(1) << 1; req_last = N'(1) << 1;
    repeat (70000) cyc();
    req_valid = '0;
    stat_sel = 4'd1;
    cyc(); cyc();
    chk("stat_sat", 32'(stat_cnt), 32'hFFFF);
    stat_sel = 4'd12;
    cyc(); cyc();
    chk("stat_oob", 32'(stat_cnt), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
